// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator over a raster pixel stream.
// Two line buffers feed a shift register; one window per accepted pixel once rows/cols >= 2.
module window_gen_3x3 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 960
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [7:0]  px_in,
    output logic        win_valid,
    output logic [71:0] win_out,
    output logic [15:0] ctr_row,
    output logic [15:0] ctr_col,
    output logic        done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_STREAM,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [7:0]    r_lb0 [IMG_W];
    logic [7:0]    r_lb1 [IMG_W];
    logic [71:0]   r_win;
    logic [71:0]   w_win_nxt;
    logic [71:0]   r_win_out;
    logic          r_win_valid;
    logic [15:0]   r_ctr_row;
    logic [15:0]   r_ctr_col;
    logic          w_accept;
    logic          w_eol;
    logic          w_fire;
    logic [7:0]    w_top;
    logic [7:0]    w_mid;
    logic [RW-1:0] w_row_m1;
    logic [CW-1:0] w_col_m1;

    assign w_accept = valid_in && (r_state != S_DONE);
    assign w_eol    = (r_col == COL_LAST);
    // STREAM implies row >= 2; cols 0/1 still hold the previous row's pixels
    assign w_fire   = w_accept && (r_state == S_STREAM) && (r_col >= CW'(2));
    assign w_top    = r_lb1[r_col];
    assign w_mid    = r_lb0[r_col];
    assign w_row_m1 = r_row - RW'(1);
    assign w_col_m1 = r_col - CW'(1);

    always_comb begin
        w_win_nxt = r_win;
        for (int i = 0; i < 3; i++) begin
            w_win_nxt[24*i +: 8]     = r_win[24*i + 8 +: 8];
            w_win_nxt[24*i + 8 +: 8] = r_win[24*i + 16 +: 8];
        end
        w_win_nxt[16 +: 8] = w_top;
        w_win_nxt[40 +: 8] = w_mid;
        w_win_nxt[64 +: 8] = px_in;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_FILL: begin
                if (w_accept && w_eol && (r_row == RW'(1)))
                    w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (w_accept && w_eol && (r_row == ROW_LAST))
                    w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_eol) begin
                r_col <= '0;
                if (r_row != ROW_LAST)
                    r_row <= r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Line buffers are never reset; FILL gating hides their contents
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= px_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win       <= '0;
            r_win_out   <= '0;
            r_win_valid <= 1'b0;
            r_ctr_row   <= '0;
            r_ctr_col   <= '0;
        end else begin
            r_win_valid <= w_fire;
            if (w_accept)
                r_win <= w_win_nxt;
            if (w_fire) begin
                r_win_out <= w_win_nxt;
                r_ctr_row <= 16'(w_row_m1);
                r_ctr_col <= 16'(w_col_m1);
            end
        end
    end

    assign win_valid = r_win_valid;
    assign win_out   = r_win_out;
    assign ctr_row   = r_ctr_row;
    assign ctr_col   = r_ctr_col;
    assign done      = (r_state == S_DONE);

endmodule
